// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction-decode stage of the multicycle LA32R core.
//
// Captures the fetched PC, decodes the instruction word presented by the
// instruction SRAM during STATE_ID, reads the 32x32 register file, resolves
// branches into a registered br_bus for the fetch stage, and presents the
// decoded operand/control bundle to the execute stage in the same cycle.
//
// Optional feature (macro ID_INVALID_INST_EN): adds the sticky output
// ds_inst_invalid, set when an undecoded instruction leaves STATE_ID and
// cleared only by reset.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   state             global state (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   next_state        requested next state
//   fs_to_ds_valid    fetch stage is in STATE_IF
//   fs_to_ds_bus      PC of the instruction being fetched
//   inst_sram_rdata   instruction word, valid during STATE_ID
//   ws_to_rf_bus      {rf_we, rf_waddr[4:0], rf_wdata[31:0]} from writeback
//   br_bus            {br_taken, br_target}, registered
//   ds_to_es_valid    high during STATE_ID
//   ds_to_es_bus      {alu_op[11:0], src1_is_pc, src2_is_imm, src2_is_4,
//                      res_from_mem, gr_we, mem_we, dest[4:0], rj_value,
//                      rkd_value, imm, ds_pc}
//   ds_inst_invalid   (ID_INVALID_INST_EN only) sticky undecoded flag
// ---------------------------------------------------------------------------
module id_stage #(
  parameter logic [31:0] RESET_PC_M4 = 32'h1bfffffc
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   state,
  output logic [3:0]   next_state,
  input  logic         fs_to_ds_valid,
  input  logic [31:0]  fs_to_ds_bus,
  input  logic [31:0]  inst_sram_rdata,
  input  logic [37:0]  ws_to_rf_bus,
  output logic [32:0]  br_bus,
  output logic         ds_to_es_valid,
`ifdef ID_INVALID_INST_EN
  output logic         ds_inst_invalid,
`endif
  output logic [150:0] ds_to_es_bus
);

  localparam logic [3:0] STATE_IF = 4'd0;
  localparam logic [3:0] STATE_ID = 4'd1;
  localparam logic [3:0] STATE_EX = 4'd2;

  logic [31:0] ds_pc;
  logic [31:0] inst;
  logic [31:0] rf [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

  assign inst = inst_sram_rdata;

  // Field extraction
  logic [4:0]  rd, rj, rk;
  logic [16:0] op_31_15;
  logic [9:0]  op_31_22;
  logic [6:0]  op_31_25;
  logic [5:0]  op_31_26;
  assign rd       = inst[4:0];
  assign rj       = inst[9:5];
  assign rk       = inst[14:10];
  assign op_31_15 = inst[31:15];
  assign op_31_22 = inst[31:22];
  assign op_31_25 = inst[31:25];
  assign op_31_26 = inst[31:26];

  logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
  logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
  logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_valid;

  assign inst_add   = op_31_15 == 17'h00020;
  assign inst_sub   = op_31_15 == 17'h00022;
  assign inst_slt   = op_31_15 == 17'h00024;
  assign inst_sltu  = op_31_15 == 17'h00025;
  assign inst_nor   = op_31_15 == 17'h00028;
  assign inst_and   = op_31_15 == 17'h00029;
  assign inst_or    = op_31_15 == 17'h0002a;
  assign inst_xor   = op_31_15 == 17'h0002b;
  assign inst_slli  = op_31_15 == 17'h00081;
  assign inst_srli  = op_31_15 == 17'h00089;
  assign inst_srai  = op_31_15 == 17'h00091;
  assign inst_addi  = op_31_22 == 10'h00a;
  assign inst_ld    = op_31_22 == 10'h0a2;
  assign inst_st    = op_31_22 == 10'h0a6;
  assign inst_lu12i = op_31_25 == 7'h0a;
  assign inst_jirl  = op_31_26 == 6'h13;
  assign inst_b     = op_31_26 == 6'h14;
  assign inst_bl    = op_31_26 == 6'h15;
  assign inst_beq   = op_31_26 == 6'h16;
  assign inst_bne   = op_31_26 == 6'h17;

  assign inst_valid = inst_add | inst_sub | inst_slt | inst_sltu | inst_and | inst_or |
                      inst_nor | inst_xor | inst_slli | inst_srli | inst_srai | inst_addi |
                      inst_lu12i | inst_ld | inst_st | inst_jirl | inst_b | inst_bl |
                      inst_beq | inst_bne;

  logic [11:0] alu_op;
  assign alu_op = {inst_lu12i, inst_srai, inst_srli, inst_slli, inst_xor, inst_or, inst_nor,
                   inst_and, inst_sltu, inst_slt, inst_sub,
                   inst_add | inst_addi | inst_ld | inst_st | inst_bl | inst_jirl};

  logic src1_is_pc, src2_is_imm, src2_is_4, res_from_mem, gr_we, mem_we;
  logic [4:0] dest;
  assign src1_is_pc   = inst_bl | inst_jirl;
  assign src2_is_4    = inst_bl | inst_jirl;
  assign src2_is_imm  = inst_slli | inst_srli | inst_srai | inst_addi | inst_ld | inst_st |
                        inst_lu12i;
  assign res_from_mem = inst_ld;
  assign mem_we       = inst_st;
  assign gr_we        = inst_valid & ~inst_st & ~inst_b & ~inst_beq & ~inst_bne;
  assign dest         = inst_bl ? 5'd1 : rd;

  // Immediate selection
  logic [31:0] imm;
  always_comb begin
    imm = 32'd0;
    if (inst_addi | inst_ld | inst_st)
      imm = {{20{inst[21]}}, inst[21:10]};
    else if (inst_slli | inst_srli | inst_srai)
      imm = {27'd0, inst[14:10]};
    else if (inst_lu12i)
      imm = {inst[24:5], 12'd0};
    else if (inst_beq | inst_bne | inst_jirl)
      imm = {{14{inst[25]}}, inst[25:10], 2'b00};
    else if (inst_b | inst_bl)
      imm = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  end

  // Register file: async reads, r0 hard-wired to zero, contents not reset.
  // beq/bne/st.w compare or store rd, so the second port switches to rd.
  logic [4:0]  raddr2;
  logic [31:0] rj_value, rkd_value;
  assign raddr2    = (inst_beq | inst_bne | inst_st) ? rd : rk;
  assign rj_value  = (rj == 5'd0) ? 32'd0 : rf[rj];
  assign rkd_value = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0)
      rf[rf_waddr] <= rf_wdata;
  end

  // Branch resolution; not-taken targets are forced to zero so br_bus
  // carries no stale address for non-branch instructions.
  logic        br_taken;
  logic [31:0] br_target;
  assign br_taken  = inst_b | inst_bl | inst_jirl |
                     (inst_beq & (rj_value == rkd_value)) |
                     (inst_bne & (rj_value != rkd_value));
  assign br_target = !br_taken ? 32'd0 :
                     inst_jirl ? rj_value + imm : ds_pc + imm;

  // ds_pc / br_bus registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_pc  <= RESET_PC_M4;
      br_bus <= 33'd0;
    end else begin
      if (fs_to_ds_valid)
        ds_pc <= fs_to_ds_bus;
      if (state == STATE_ID)
        br_bus <= {br_taken, br_target};
    end
  end

`ifdef ID_INVALID_INST_EN
  always_ff @(posedge clk) begin
    if (reset)
      ds_inst_invalid <= 1'b0;
    else if (state == STATE_ID && !inst_valid)
      ds_inst_invalid <= 1'b1;
  end
`endif

  assign next_state     = reset ? STATE_IF : (state == STATE_ID) ? STATE_EX : STATE_IF;
  assign ds_to_es_valid = (state == STATE_ID) & ~reset;

  assign ds_to_es_bus = {alu_op, src1_is_pc, src2_is_imm, src2_is_4, res_from_mem,
                         gr_we, mem_we, dest, rj_value, rkd_value, imm, ds_pc};

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic         clk;
  logic         reset;
  logic [3:0]   state;
  logic [3:0]   next_state;
  logic         fs_to_ds_valid;
  logic [31:0]  fs_to_ds_bus;
  logic [31:0]  inst_sram_rdata;
  logic [37:0]  ws_to_rf_bus;
  logic [32:0]  br_bus;
  logic         ds_to_es_valid;
  logic [150:0] ds_to_es_bus;
`ifdef ID_INVALID_INST_EN
  logic         ds_inst_invalid;
`endif

  int nvec = 0;
  int nfail = 0;

  localparam logic [3:0] S_IF = 4'd0, S_ID = 4'd1, S_EX = 4'd2, S_MEM = 4'd3, S_WB = 4'd4;

  id_stage dut (
    .clk             (clk),
    .reset           (reset),
    .state           (state),
    .next_state      (next_state),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .ws_to_rf_bus    (ws_to_rf_bus),
    .br_bus          (br_bus),
    .ds_to_es_valid  (ds_to_es_valid),
`ifdef ID_INVALID_INST_EN
    .ds_inst_invalid (ds_inst_invalid),
`endif
    .ds_to_es_bus    (ds_to_es_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [150:0] obs, input logic [150:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_if(input logic [31:0] pc);
    state = S_IF;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = pc;
    tick();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic do_id(input logic [31:0] word);
    state = S_ID;
    inst_sram_rdata = word;
    #1;
  endtask

  task automatic wr_rf(input logic [4:0] a, input logic [31:0] d);
    state = S_WB;
    ws_to_rf_bus = {1'b1, a, d};
    tick();
    ws_to_rf_bus = 38'd0;
  endtask

  // Bus field views
  function automatic logic [11:0] f_alu(input logic [150:0] b); return b[150:139]; endfunction
  function automatic logic [4:0]  f_dest(input logic [150:0] b); return b[132:128]; endfunction
  function automatic logic [31:0] f_rj(input logic [150:0] b); return b[127:96]; endfunction
  function automatic logic [31:0] f_rkd(input logic [150:0] b); return b[95:64]; endfunction
  function automatic logic [31:0] f_imm(input logic [150:0] b); return b[63:32]; endfunction
  function automatic logic [31:0] f_pc(input logic [150:0] b); return b[31:0]; endfunction
  // flags: {src1_is_pc, src2_is_imm, src2_is_4, res_from_mem, gr_we, mem_we}
  function automatic logic [5:0]  f_flags(input logic [150:0] b); return b[138:133]; endfunction

  initial begin
    reset = 1'b1;
    state = S_IF;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus = 32'd0;
    inst_sram_rdata = 32'd0;
    ws_to_rf_bus = 38'd0;
    tick();
    tick();

    // Reset state
    check("rst_br_bus", br_bus, 33'd0);
    check("rst_next_state", next_state, S_IF);
    check("rst_valid", ds_to_es_valid, 1'b0);
    check("rst_ds_pc", f_pc(ds_to_es_bus), 32'h1bfffffc);
`ifdef ID_INVALID_INST_EN
    check("rst_invalid", ds_inst_invalid, 1'b0);
`endif

    // 1: addi.w r1,r0,0x7ff
    reset = 1'b0;
    do_if(32'h1c000000);
    do_id(32'h029ffc01);
    check("addi_alu", f_alu(ds_to_es_bus), 12'h001);
    check("addi_flags", f_flags(ds_to_es_bus), 6'b010010);
    check("addi_dest", f_dest(ds_to_es_bus), 5'd1);
    check("addi_imm", f_imm(ds_to_es_bus), 32'h000007ff);
    check("addi_pc", f_pc(ds_to_es_bus), 32'h1c000000);
    check("addi_next", next_state, S_EX);
    check("addi_valid", ds_to_es_valid, 1'b1);
    tick();
    check("addi_br_bus", br_bus, 33'd0);

    // 2: beq r4,r5 taken
    wr_rf(5'd4, 32'd5);
    wr_rf(5'd5, 32'd5);
    do_if(32'h1c000010);
    do_id(32'h58001085);
    check("beq_rj", f_rj(ds_to_es_bus), 32'd5);
    check("beq_rkd", f_rkd(ds_to_es_bus), 32'd5);
    check("beq_gr_we", f_flags(ds_to_es_bus), 6'b000000);
    tick();
    check("beq_br_bus", br_bus, {1'b1, 32'h1c000020});
    state = S_EX;  tick();
    state = S_MEM; tick();
    state = S_WB;  tick();
    state = S_IF;  tick();
    check("beq_br_hold", br_bus, {1'b1, 32'h1c000020});

    // 3: bne not taken, then b offs26=-1
    do_if(32'h1c000010);
    do_id(32'h5c001085);
    tick();
    check("bne_taken", br_bus[32], 1'b0);
    state = S_EX; tick();
    do_if(32'h1c000000);
    do_id(32'h53ffffff);
    check("b_imm", f_imm(ds_to_es_bus), 32'hfffffffc);
    tick();
    check("b_br_bus", br_bus, {1'b1, 32'h1bfffffc});

    // 4: write r0 is ignored; add.w r2,r0,r0
    wr_rf(5'd0, 32'hdeadbeef);
    do_if(32'h1c000020);
    do_id(32'h00100002);
    check("r0_rj", f_rj(ds_to_es_bus), 32'd0);
    check("r0_rkd", f_rkd(ds_to_es_bus), 32'd0);
    check("add_alu", f_alu(ds_to_es_bus), 12'h001);
    check("add_dest", f_dest(ds_to_es_bus), 5'd2);
    tick();

    // 5: bl offs26=8
    do_if(32'h1c000100);
    do_id(32'h54002000);
    check("bl_dest", f_dest(ds_to_es_bus), 5'd1);
    check("bl_src1_pc", ds_to_es_bus[138], 1'b1);
    check("bl_src2_4", ds_to_es_bus[136], 1'b1);
    check("bl_gr_we", ds_to_es_bus[134], 1'b1);
    check("bl_alu", f_alu(ds_to_es_bus), 12'h001);
    tick();
    check("bl_br_bus", br_bus, {1'b1, 32'h1c000120});

    // jirl r1,r4,4 -> target r4+16
    state = S_EX; tick();
    do_if(32'h1c000200);
    do_id(32'h4c001081);
    check("jirl_imm", f_imm(ds_to_es_bus), 32'h00000010);
    tick();
    check("jirl_br_bus", br_bus, {1'b1, 32'h00000015});

    // Reset during MEM while a taken branch is held
    state = S_MEM;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_br_bus", br_bus, 33'd0);
    check("midrst_ds_pc", f_pc(ds_to_es_bus), 32'h1bfffffc);

    // st.w r5,r4,8 reads rd on port 2
    do_if(32'h1c000300);
    do_id(32'h29802085);
    check("st_flags", f_flags(ds_to_es_bus), 6'b010001);
    check("st_rkd", f_rkd(ds_to_es_bus), 32'd5);
    check("st_imm", f_imm(ds_to_es_bus), 32'd8);
    tick();

    // lu12i.w r6,0x12345
    do_if(32'h1c000304);
    do_id(32'h142468a6);
    check("lu12i_alu", f_alu(ds_to_es_bus), 12'h800);
    check("lu12i_imm", f_imm(ds_to_es_bus), 32'h12345000);
    tick();

    // srai.w r7,r4,31
    do_if(32'h1c000308);
    do_id(32'h0048fc87);
    check("srai_alu", f_alu(ds_to_es_bus), 12'h400);
    check("srai_imm", f_imm(ds_to_es_bus), 32'h0000001f);
    tick();

    // 6: undecoded instruction, then reset during EX
    do_if(32'h1c00030c);
    do_id(32'hffffffff);
    check("inv_ctrl", ds_to_es_bus[150:133], 18'd0);
    check("inv_next", next_state, S_EX);
    tick();
`ifdef ID_INVALID_INST_EN
    check("inv_flag_set", ds_inst_invalid, 1'b1);
`endif
    state = S_EX;
    reset = 1'b1;
    #1;
    check("inv_rst_next", next_state, S_IF);
    check("inv_rst_valid", ds_to_es_valid, 1'b0);
    tick();
    reset = 1'b0;
    check("inv_rst_br_bus", br_bus, 33'd0);
`ifdef ID_INVALID_INST_EN
    check("inv_flag_clr", ds_inst_invalid, 1'b0);
`endif

    // Register file survives reset: add.w r3,r4,r5
    do_id(32'h00101483);
    check("keep_rj", f_rj(ds_to_es_bus), 32'd5);
    check("keep_rkd", f_rkd(ds_to_es_bus), 32'd5);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
